fir_rom_sequencer: RTL and testbench
====================================

Name: fir_rom_sequencer

Overview:
Sequential tap engine for the ROM-based FIR filter. It is the reader/initiator side of the coefficient-ROM interface: it keeps the sample delay line and drives one shared ROM address port with each stored sample in turn. It selects the matching coefficient ROM for that tap, accumulates the returned products and presents one filter output per accepted input sample. It sits between the sample source (valid/ready) and the output consumer (valid/ready); the ROMs are external and purely combinational.

Parameters:
TAPS, 4, number of taps and coefficient ROMs (power of 2, >=2)
DW, 8, sample width = ROM address width
PW, 16, ROM product width
AW, 18, accumulator/output width = PW + log2(TAPS)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst_n  in  1  reset; asynchronous assert, active-low
in_valid  in  1  input sample valid
in_data  in  DW  input sample, unsigned
in_ready  out  1  block can accept a sample
flush  in  1  clear delay line (honoured in IDLE only)
rom_addr  out  DW  address to the coefficient ROMs = delay-line sample for the current tap
rom_sel  out  log2(TAPS)  selects coefficient ROM c[rom_sel]
rom_data  in  PW  product from selected ROM, valid in the same cycle (combinational ROM)
out_valid  out  1  filter output valid
out_data  out  AW  filter output, unsigned
out_ready  in  1  consumer accepts output

Behaviour:
- Reset (rst_n=0, any time, including mid-MAC): state=IDLE; delay line d[0..TAPS-1]=0; acc=0; idx=0; out_valid=0; out_data=0. After reset, in_ready=1 (when flush=0), rom_addr=0, rom_sel=0.
- States: IDLE, MAC, DONE.
- in_ready = (state==IDLE) & ~flush, combinational. rom_addr/rom_sel are 0 outside MAC.
- IDLE:
  - flush=1: d[*]<=0, stay IDLE. flush has priority over in_valid; the sample is not accepted because in_ready=0.
  - in_valid & in_ready: d[0]<=in_data, d[k]<=d[k-1]; acc<=0; idx<=0; ->MAC.
- MAC: rom_addr=d[idx], rom_sel=idx.
  - Each cycle: acc<=acc+zero-extended rom_data; idx<=idx+1.
  - At idx==TAPS-1: out_data<=acc+rom_data, out_valid<=1, ->DONE.
  - flush and in_valid are ignored in MAC.
- DONE: out_valid and out_data are held stable until out_ready=1. On that edge out_valid<=0, ->IDLE. flush is ignored.
- Latency: acceptance edge E; out_valid rises at edge E+TAPS. Minimum sample period is TAPS+2 cycles with out_ready tied high.
- Arithmetic: unsigned. The AW=PW+log2(TAPS) accumulator cannot overflow, so there is no saturation or wrap.
- Delay line: taps older than the oldest d[TAPS-1] are discarded. Contents persist across outputs and change only on accept, flush or reset.
- out_data is registered and keeps its last value after the DONE->IDLE handshake.

Test Plan:
1. All ROMs c=4 (rom_data=4*addr). Inputs 1,0,0,0,0 after reset -> outputs 4,4,4,4,0. First out_valid exactly 4 clocks after the accept edge.
2. ROMs c={1,4,4,1}. Inputs 255 x4 -> outputs 255, 1275, 2295, 2550. Monitor rom_sel sequence 0,1,2,3 with rom_addr=d[idx] each MAC cycle.
3. All c=4. Inputs 255 x5 -> 4th and 5th outputs = 4080 (max, no overflow, AW=18). out_ready tied 1 -> in_ready period = 6 cycles.
4. Backpressure: hold out_ready=0 for 10 cycles in DONE -> out_valid=1 and out_data constant throughout, in_ready=0, in_valid pulses not accepted. Release -> one transfer, then IDLE.
5. Flush: load 7,9 with c=4, assert flush with in_valid=1 in IDLE -> in_ready=0, no accept. Then input 1 -> output 4 (old samples cleared). Flush asserted during MAC -> no effect on the result in progress.
6. Async reset asserted mid-MAC (idx=2) -> out_valid=0, out_data=0 immediately. After release, input 3 with c=4 -> output 12 (delay line was cleared).

Source files
------------

// File: rtl/fir_rom_sequencer.sv
// Sequential tap engine for the ROM-based FIR: one shared ROM address port,
// one tap per cycle, registered result held until the consumer takes it.
module fir_rom_sequencer #(
  parameter int TAPS = 4,
  parameter int DW   = 8,
  parameter int PW   = 16,
  parameter int AW   = 18,
  localparam int SW  = $clog2(TAPS)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [DW-1:0] in_data,
  output logic          in_ready,
  input  logic          flush,
  output logic [DW-1:0] rom_addr,
  output logic [SW-1:0] rom_sel,
  input  logic [PW-1:0] rom_data,
  output logic          out_valid,
  output logic [AW-1:0] out_data,
  input  logic          out_ready
);

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                  state, state_nxt;
  logic [TAPS-1:0][DW-1:0] dline;
  logic [AW-1:0]           acc;
  logic [AW-1:0]           sum;
  logic [SW-1:0]           idx;
  logic                    last;
  logic                    accept;
  logic                    clr;

  assign sum    = acc + {{(AW-PW){1'b0}}, rom_data};
  assign last   = (idx == SW'(TAPS-1));
  assign clr    = (state == IDLE) & flush;
  assign accept = in_valid & in_ready;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)    state_nxt = MAC;
      MAC:     if (last)      state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default:                state_nxt = IDLE;
    endcase
  end

  // ROM port is parked at 0 whenever no tap is being read
  always_comb begin
    in_ready = (state == IDLE) & ~flush;
    rom_addr = '0;
    rom_sel  = '0;
    if (state == MAC) begin
      rom_addr = dline[idx];
      rom_sel  = idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      dline     <= '0;
      acc       <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clr) dline <= '0;
          else if (accept) begin
            dline <= {dline[TAPS-2:0], in_data};
            acc   <= '0;
            idx   <= '0;
          end
        end
        MAC: begin
          acc <= sum;
          idx <= idx + SW'(1);
          if (last) begin
            out_data  <= sum;
            out_valid <= 1'b1;
          end
        end
        DONE: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end

endmodule

// File: tb/tb_fir_rom_sequencer.sv
// Self-checking bench: table vectors from the test plan, hand-built corner
// sequences, and random traffic checked against a sum-of-products model.
module tb_fir_rom_sequencer;
  localparam int TAPS = 4, DW = 8, PW = 16, AW = 18, SW = 2;

  logic          clk = 0, rst_n = 0;
  logic          in_valid = 0, flush = 0, out_ready = 1;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid;
  logic [DW-1:0] rom_addr;
  logic [SW-1:0] rom_sel;
  logic [PW-1:0] rom_data;
  logic [AW-1:0] out_data;

  fir_rom_sequencer #(.TAPS(TAPS), .DW(DW), .PW(PW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .flush(flush), .rom_addr(rom_addr), .rom_sel(rom_sel),
    .rom_data(rom_data), .out_valid(out_valid), .out_data(out_data),
    .out_ready(out_ready));

  always #5 clk = ~clk;

  int     coef[TAPS];
  int     hist[$];
  int     checks = 0, errors = 0;
  longint accept_t = 0, prev_accept_t = 0;

  // Coefficient ROMs: product of the selected coefficient and the address
  always_comb rom_data = PW'(coef[rom_sel] * int'(rom_addr));

  typedef struct {
    bit                 rst;
    bit [TAPS-1:0][7:0] c;
    int                 x;
    int                 exp;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input bit r, input bit [TAPS-1:0][7:0] c,
                              input int x, input int e);
    vec_t v;
    v.rst = r; v.c = c; v.x = x; v.exp = e;
    return v;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int model_out();
    int s = 0;
    for (int k = 0; k < TAPS; k++) s += coef[k] * hist[k];
    return s;
  endfunction

  task automatic model_clear();
    hist.delete();
    repeat (TAPS) hist.push_back(0);
  endtask

  task automatic model_push(input int x);
    hist.push_front(x);
    void'(hist.pop_back());
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 0; in_valid = 0; flush = 0; out_ready = 1;
    @(negedge clk);
    chk("reset_state", {in_ready, out_valid, out_data, rom_addr, rom_sel},
        {1'b1, 1'b0, 18'd0, 8'd0, 2'd0});
    @(negedge clk);
    rst_n = 1;
    model_clear();
  endtask

  // One sample through the engine; hold>0 keeps out_ready low that many cycles
  task automatic send(input int x, input int hold, input bit mac_flush, output int got);
    int n, lat, bad;
    @(negedge clk);
    in_valid = 1; in_data = x[7:0]; out_ready = (hold == 0); n = 0;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    chk("accept_wait", longint'(n < 50), 1);
    @(posedge clk);
    prev_accept_t = accept_t; accept_t = $time;
    model_push(x);
    @(negedge clk);
    in_valid = 0; flush = mac_flush; lat = 0; bad = 0;
    while (!out_valid && lat < 50) begin
      if (lat >= TAPS || rom_sel !== SW'(lat) || int'(rom_addr) != hist[lat]) bad++;
      @(negedge clk); lat++;
    end
    flush = 0;
    chk("latency", lat, TAPS);
    chk("mac_seq", bad, 0);
    got = int'(out_data);
    if (hold > 0) begin
      bad = 0;
      repeat (hold) begin
        in_valid = ~in_valid; in_data = 8'hAA;
        @(negedge clk);
        if (!out_valid || int'(out_data) != got || in_ready) bad++;
      end
      in_valid = 0; out_ready = 1;
      @(negedge clk);
      chk("bp_hold", bad, 0);
      chk("bp_release", {out_valid, in_ready, out_data}, {1'b0, 1'b1, AW'(got)});
    end
  endtask

  initial begin
    int got;
    tbl[0]  = mk(1, {4{8'd4}}, 1, 4);
    tbl[1]  = mk(0, {4{8'd4}}, 0, 4);
    tbl[2]  = mk(0, {4{8'd4}}, 0, 4);
    tbl[3]  = mk(0, {4{8'd4}}, 0, 4);
    tbl[4]  = mk(0, {4{8'd4}}, 0, 0);
    tbl[5]  = mk(1, {8'd1, 8'd4, 8'd4, 8'd1}, 255, 255);
    tbl[6]  = mk(0, {8'd1, 8'd4, 8'd4, 8'd1}, 255, 1275);
    tbl[7]  = mk(0, {8'd1, 8'd4, 8'd4, 8'd1}, 255, 2295);
    tbl[8]  = mk(0, {8'd1, 8'd4, 8'd4, 8'd1}, 255, 2550);
    tbl[9]  = mk(1, {4{8'd4}}, 255, 1020);
    tbl[10] = mk(0, {4{8'd4}}, 255, 2040);
    tbl[11] = mk(0, {4{8'd4}}, 255, 3060);
    tbl[12] = mk(0, {4{8'd4}}, 255, 4080);
    tbl[13] = mk(0, {4{8'd4}}, 255, 4080);
    model_clear();
    for (int k = 0; k < TAPS; k++) coef[k] = 4;

    for (int i = 0; i < 14; i++) begin
      if (tbl[i].rst) do_reset();
      for (int k = 0; k < TAPS; k++) coef[k] = int'(tbl[i].c[k]);
      send(tbl[i].x, 0, 0, got);
      chk("vec_out", got, tbl[i].exp);
      if (!tbl[i].rst) chk("in_period", accept_t - prev_accept_t, (TAPS + 2) * 10);
    end

    // backpressure: 10 stalled cycles, then a single transfer
    send(100, 10, 0, got);
    chk("bp_out", got, model_out());
    send(0, 0, 0, got);
    chk("bp_next", got, model_out());

    // flush in IDLE blocks the sample and clears the history
    do_reset();
    send(7, 0, 0, got);
    send(9, 0, 0, got);
    @(negedge clk);
    flush = 1; in_valid = 1; in_data = 8'd55;
    #1 chk("flush_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    chk("flush_idle", {out_valid, rom_sel}, {1'b0, 2'd0});
    flush = 0; in_valid = 0;
    model_clear();
    send(1, 0, 0, got);
    chk("flush_out", got, 4);
    send(2, 0, 1, got);
    chk("flush_mac", got, 12);

    // async reset in the middle of a MAC
    do_reset();
    send(5, 0, 0, got);
    chk("pre_rst_out", got, 20);
    @(negedge clk);
    in_valid = 1; in_data = 8'd9;
    @(posedge clk);
    @(negedge clk); in_valid = 0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_mac_sel", rom_sel, 2);
    #1 rst_n = 0;
    #1 chk("async_rst", {out_valid, out_data, rom_addr, rom_sel, in_ready},
           {1'b0, 18'd0, 8'd0, 2'd0, 1'b1});
    @(negedge clk);
    rst_n = 1;
    model_clear();
    send(3, 0, 0, got);
    chk("post_rst_out", got, 12);

    // random traffic against the model
    for (int i = 0; i < 24; i++) begin
      if (i % 6 == 0)
        for (int k = 0; k < TAPS; k++) coef[k] = int'($urandom_range(0, 255));
      send(int'($urandom_range(0, 255)), (i % 5 == 4) ? int'($urandom_range(1, 3)) : 0,
           1'($urandom_range(0, 1)), got);
      chk("rand_out", got, model_out());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
